timer_cfg_arbiter: RTL and testbench
====================================

# timer_cfg_arbiter

Shares the single TIMERS block between NUM_CORES CPU cores of the multicore PLC unit. It round-robin arbitrates reload/enable requests and sequences the byte-wide TIMERS write protocol: LSB write, MSB write, then register set and enable update. It also services the TIMER1 overflow flag on behalf of all cores, clearing it in TIMERS and replicating it as a per-core sticky pending bit.

## Interface
Parameters:
- NUM_CORES, 4, number of requesting cores (2..8)

Ports:
- CLK  input  1  system clock; all logic on rising edge
- CPU_Reset  input  1  synchronous, active-high reset
- REQ  input  NUM_CORES  per-core request; hold high until ACK
- REQ_RELOAD  input  16*NUM_CORES  per-core 16-bit reload value; core i at [16i+15:16i]
- REQ_EN  input  NUM_CORES  per-core requested TIMER1 enable
- ACK  output  NUM_CORES  one-cycle completion pulse to the granted core
- BUSY  output  1  high whenever state is not IDLE
- TIMER1_EN  output  1  to TIMERS.TIMER1_EN
- TIMER_WR_LSB  output  1  to TIMERS
- TIMER_WR_MSB  output  1  to TIMERS
- TIMER_SET_REGISTER  output  1  to TIMERS
- TIMERS_DATA  output  8  to TIMERS
- TIMER1_OV_Flag  input  1  from TIMERS
- TIMER1_OV_Read  output  1  to TIMERS; one-cycle clear pulse
- OV_PEND  output  NUM_CORES  per-core sticky overflow indication
- OV_CLR  input  NUM_CORES  per-core clear of OV_PEND

## Operation
- States: IDLE, WR_LSB, WR_MSB, SET, DONE. All outputs are registered.
- IDLE with any REQ bit set:
  - Select the winner by round-robin, searching from index PTR upward with wrap.
  - Latch the winner's index, REQ_RELOAD slice and REQ_EN bit.
  - Go to WR_LSB.
- WR_LSB: TIMER_WR_LSB=1, TIMERS_DATA=latched[7:0]. Go to WR_MSB.
- WR_MSB: TIMER_WR_MSB=1, TIMERS_DATA=latched[15:8]. Go to SET.
- SET: TIMER_SET_REGISTER=1, TIMERS_DATA=latched[15:8] (held). Go to DONE.
- DONE:
  - ACK[winner]=1.
  - TIMER1_EN takes the latched enable value.
  - PTR=(winner+1) mod NUM_CORES.
  - Go to IDLE.
- Outside the states above, strobes are 0 and TIMERS_DATA holds its last value.
- Strobes are mutually exclusive. At most one ACK bit is high at any time.
- Request rules:
  - The latched request is immutable. REQ or REQ_RELOAD changing mid-transaction has no effect.
  - REQ dropping before ACK still completes the transaction and pulses ACK.
  - REQ still high in the cycle after ACK counts as a new request.
  - Simultaneous requests are served in round-robin order, so no core waits more than NUM_CORES transactions.
- Overflow servicing, independent of the state machine:
  - TIMER1_OV_Read <= TIMER1_OV_Flag & ~TIMER1_OV_Read.
  - OV_PEND[i] <= (OV_PEND[i] & ~OV_CLR[i]) | (TIMER1_OV_Flag & ~TIMER1_OV_Read).
  - When a set and an OV_CLR occur in the same cycle, the set wins.

## Timing
- Reset values: state IDLE, PTR=0, ACK=0, BUSY=0, TIMER1_EN=0, all strobes 0, TIMERS_DATA=0, TIMER1_OV_Read=0, OV_PEND=0.
- REQ is sampled at edge t:
  - WR_LSB during t+1, WR_MSB during t+2, SET during t+3.
  - ACK and the TIMER1_EN update during t+4.
  - Earliest next grant is sampled at edge t+5.
- Transaction length is fixed at 4 cycles after the sampling edge. Throughput is one transaction per 5 cycles.
- BUSY is high from t+1 through t+4 inclusive.
- Overflow: TIMER1_OV_Flag high in cycle c gives TIMER1_OV_Read=1 and OV_PEND all-ones in cycle c+1. The flag clears in TIMERS at c+2. No second pulse is issued for the same flag.
- A persistent flag (new overflow coincident with the clear) produces one Read pulse every 2 cycles.
- CPU_Reset asserted mid-transaction:
  - Next cycle is IDLE with all strobes 0 and TIMER1_EN=0.
  - No ACK is issued for the aborted request.
  - A core holding REQ is re-arbitrated after reset releases.

## Test plan
- Single request: core 2 requests RELOAD=0xA55A, EN=1 -> WR_LSB data 0x5A, WR_MSB data 0xA5, SET, then ACK[2]=1 and TIMER1_EN=1 exactly 4 cycles after sampling.
- Contention: cores 0,1,3 request together with PTR=0 -> grants in order 0,1,3. Each ACK is 5 cycles apart with correct per-core data bytes. PTR=0 after core 3.
- Fairness: core 0 re-requests continuously while core 1 has a single request pending -> core 1 is granted next after core 0's ACK.
- Data stability: core 1 changes REQ_RELOAD from 0x1234 to 0xFFFF during WR_LSB -> bytes written are 0x34 then 0x12.
- Overflow: TIMER1_OV_Flag pulses high -> one TIMER1_OV_Read pulse and OV_PEND=all-ones. OV_CLR[1] clears only bit 1. OV_CLR[0] coincident with a new overflow leaves bit 0 set.
- Reset mid-operation: CPU_Reset in the WR_MSB cycle -> no SET strobe, no ACK, TIMER1_EN=0, BUSY=0. The held request is re-served from WR_LSB after release.

Source files
------------

// File: rtl/timer_cfg_arbiter.sv
// timer_cfg_arbiter: round-robin sharing of the TIMERS reload/enable port, plus TIMER1 overflow fan-out
module timer_cfg_arbiter #(
  parameter int NUM_CORES = 4
) (
  input  logic                      CLK,
  input  logic                      CPU_Reset,
  input  logic [NUM_CORES-1:0]      REQ,
  input  logic [16*NUM_CORES-1:0]   REQ_RELOAD,
  input  logic [NUM_CORES-1:0]      REQ_EN,
  output logic [NUM_CORES-1:0]      ACK,
  output logic                      BUSY,
  output logic                      TIMER1_EN,
  output logic                      TIMER_WR_LSB,
  output logic                      TIMER_WR_MSB,
  output logic                      TIMER_SET_REGISTER,
  output logic [7:0]                TIMERS_DATA,
  input  logic                      TIMER1_OV_Flag,
  output logic                      TIMER1_OV_Read,
  output logic [NUM_CORES-1:0]      OV_PEND,
  input  logic [NUM_CORES-1:0]      OV_CLR
);
  localparam int IW = $clog2(NUM_CORES);
  typedef enum logic [2:0] {IDLE, WR_LSB, WR_MSB, SET, DONE} state_t;
  state_t state;
  logic [IW-1:0] ptr, win, pick;
  logic [NUM_CORES-1:0][15:0] rl;
  logic [7:0] reload_hi;
  logic en;
  logic ov_new;
  int s;
  assign rl = REQ_RELOAD;
  assign ov_new = TIMER1_OV_Flag & ~TIMER1_OV_Read;
  // descending scan so the requester closest above ptr (with wrap) wins
  always_comb begin
    pick = ptr;
    s = 0;
    for (int j = NUM_CORES - 1; j >= 0; j--) begin
      s = int'(ptr) + j;
      s = s >= NUM_CORES ? s - NUM_CORES : s;
      pick = REQ[IW'(s)] ? IW'(s) : pick;
    end
  end
  always_ff @(posedge CLK) begin
    if (CPU_Reset) begin
      state <= IDLE;
      ptr <= '0;
      win <= '0;
      reload_hi <= '0;
      en <= 1'b0;
      ACK <= '0;
      BUSY <= 1'b0;
      TIMER1_EN <= 1'b0;
      TIMER_WR_LSB <= 1'b0;
      TIMER_WR_MSB <= 1'b0;
      TIMER_SET_REGISTER <= 1'b0;
      TIMERS_DATA <= '0;
    end else begin
      ACK <= '0;
      TIMER_WR_LSB <= 1'b0;
      TIMER_WR_MSB <= 1'b0;
      TIMER_SET_REGISTER <= 1'b0;
      case (state)
        IDLE: if (|REQ) begin
          win <= pick;
          reload_hi <= rl[pick][15:8];
          en <= REQ_EN[pick];
          state <= WR_LSB;
          BUSY <= 1'b1;
          TIMER_WR_LSB <= 1'b1;
          TIMERS_DATA <= rl[pick][7:0];
        end
        WR_LSB: begin
          state <= WR_MSB;
          TIMER_WR_MSB <= 1'b1;
          TIMERS_DATA <= reload_hi;
        end
        WR_MSB: begin
          state <= SET;
          TIMER_SET_REGISTER <= 1'b1;
        end
        SET: begin
          state <= DONE;
          ACK <= NUM_CORES'(1) << win;
          TIMER1_EN <= en;
          ptr <= win == IW'(NUM_CORES - 1) ? '0 : win + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          BUSY <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // the read pulse suppresses itself for one cycle so a single flag clears once
  always_ff @(posedge CLK) begin
    if (CPU_Reset) begin
      TIMER1_OV_Read <= 1'b0;
      OV_PEND <= '0;
    end else begin
      TIMER1_OV_Read <= ov_new;
      OV_PEND <= (OV_PEND & ~OV_CLR) | {NUM_CORES{ov_new}};
    end
  end
endmodule

// File: tb/tb_timer_cfg_arbiter.sv
// tb_timer_cfg_arbiter: directed stimulus with a schedule-based reference model checked every cycle
module tb_timer_cfg_arbiter;
  localparam int N = 4;
  localparam int M = 1024;
  logic CLK, CPU_Reset;
  logic [N-1:0] REQ, REQ_EN, ACK, OV_PEND, OV_CLR;
  logic [16*N-1:0] REQ_RELOAD;
  logic BUSY, TIMER1_EN, TIMER_WR_LSB, TIMER_WR_MSB, TIMER_SET_REGISTER;
  logic [7:0] TIMERS_DATA;
  logic TIMER1_OV_Flag, TIMER1_OV_Read;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit armed = 0;
  timer_cfg_arbiter #(.NUM_CORES(N)) dut (
    .CLK(CLK), .CPU_Reset(CPU_Reset), .REQ(REQ), .REQ_RELOAD(REQ_RELOAD), .REQ_EN(REQ_EN),
    .ACK(ACK), .BUSY(BUSY), .TIMER1_EN(TIMER1_EN), .TIMER_WR_LSB(TIMER_WR_LSB),
    .TIMER_WR_MSB(TIMER_WR_MSB), .TIMER_SET_REGISTER(TIMER_SET_REGISTER),
    .TIMERS_DATA(TIMERS_DATA), .TIMER1_OV_Flag(TIMER1_OV_Flag), .TIMER1_OV_Read(TIMER1_OV_Read),
    .OV_PEND(OV_PEND), .OV_CLR(OV_CLR)
  );
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask
  // reference model: a grant schedules its whole output timeline into per-cycle tables
  bit s_lsb[M], s_msb[M], s_set[M], s_busy[M], s_dv[M], s_env[M], s_en[M];
  bit [7:0] s_d[M];
  bit [N-1:0] s_ack[M];
  int m_ptr, m_free;
  bit e_lsb, e_msb, e_set, e_busy, e_en, e_rd;
  bit [7:0] e_data;
  bit [N-1:0] e_ack, e_pend;
  initial forever begin
    int w, idx;
    bit nrd;
    logic [N-1:0][15:0] rl;
    @(posedge CLK);
    cyc++;
    if (cyc > M - 8) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, M - 8);
      $fatal(1);
    end
    if (CPU_Reset) begin
      armed = 1;
      m_ptr = 0;
      m_free = cyc + 1;
      e_data = 0;
      e_en = 0;
      e_rd = 0;
      e_pend = 0;
      for (int i = 0; i < 4; i++) begin
        s_lsb[cyc+i] = 0; s_msb[cyc+i] = 0; s_set[cyc+i] = 0; s_busy[cyc+i] = 0;
        s_dv[cyc+i] = 0; s_env[cyc+i] = 0; s_ack[cyc+i] = 0;
      end
    end else begin
      if (cyc >= m_free && REQ != 0) begin
        w = -1;
        for (int j = 0; j < N; j++) begin
          idx = (m_ptr + j) % N;
          if (w < 0 && REQ[idx[1:0]]) w = idx;
        end
        rl = REQ_RELOAD;
        s_lsb[cyc] = 1; s_msb[cyc+1] = 1; s_set[cyc+2] = 1;
        s_ack[cyc+3] = N'(1) << w;
        for (int i = 0; i < 4; i++) s_busy[cyc+i] = 1;
        for (int i = 0; i < 3; i++) s_dv[cyc+i] = 1;
        s_d[cyc] = rl[w[1:0]][7:0];
        s_d[cyc+1] = rl[w[1:0]][15:8];
        s_d[cyc+2] = rl[w[1:0]][15:8];
        s_env[cyc+3] = 1;
        s_en[cyc+3] = REQ_EN[w[1:0]];
        m_ptr = (w + 1) % N;
        m_free = cyc + 5;
      end
      nrd = TIMER1_OV_Flag & ~e_rd;
      e_pend = (e_pend & ~OV_CLR) | {N{nrd}};
      e_rd = nrd;
    end
    e_lsb = s_lsb[cyc]; e_msb = s_msb[cyc]; e_set = s_set[cyc];
    e_busy = s_busy[cyc]; e_ack = s_ack[cyc];
    e_data = s_dv[cyc] ? s_d[cyc] : e_data;
    e_en = s_env[cyc] ? s_en[cyc] : e_en;
  end
  initial forever begin
    @(negedge CLK);
    if (armed) begin
      chk("ack", 32'(ACK), 32'(e_ack));
      chk("busy", 32'(BUSY), 32'(e_busy));
      chk("timer1_en", 32'(TIMER1_EN), 32'(e_en));
      chk("wr_lsb", 32'(TIMER_WR_LSB), 32'(e_lsb));
      chk("wr_msb", 32'(TIMER_WR_MSB), 32'(e_msb));
      chk("set_reg", 32'(TIMER_SET_REGISTER), 32'(e_set));
      chk("data", 32'(TIMERS_DATA), 32'(e_data));
      chk("ov_read", 32'(TIMER1_OV_Read), 32'(e_rd));
      chk("ov_pend", 32'(OV_PEND), 32'(e_pend));
    end
  end
  initial begin
    int order[$];
    int at[$];
    int lsb_bytes[$];
    CPU_Reset = 1; REQ = 0; REQ_EN = 0; REQ_RELOAD = 0; OV_CLR = 0; TIMER1_OV_Flag = 0;
    tick(2);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_ack", 32'(ACK), 32'd0);
    chk("rst_data", 32'(TIMERS_DATA), 32'd0);
    chk("rst_pend", 32'(OV_PEND), 32'd0);
    chk("rst_en", 32'(TIMER1_EN), 32'd0);
    // single request from core 2
    CPU_Reset = 0;
    REQ = 4'b0100; REQ_EN = 4'b0100; REQ_RELOAD[32 +: 16] = 16'hA55A;
    tick(1);
    chk("t1_lsb", 32'(TIMER_WR_LSB), 32'd1);
    chk("t1_lsb_data", 32'(TIMERS_DATA), 32'h5A);
    tick(1);
    chk("t1_msb", 32'(TIMER_WR_MSB), 32'd1);
    chk("t1_msb_data", 32'(TIMERS_DATA), 32'hA5);
    tick(1);
    chk("t1_set", 32'(TIMER_SET_REGISTER), 32'd1);
    chk("t1_set_data", 32'(TIMERS_DATA), 32'hA5);
    tick(1);
    chk("t1_ack", 32'(ACK), 32'b0100);
    chk("t1_en", 32'(TIMER1_EN), 32'd1);
    REQ = 0; REQ_EN = 0;
    tick(2);
    // contention with pointer back at 0
    CPU_Reset = 1;
    tick(1);
    CPU_Reset = 0;
    REQ_RELOAD[0 +: 16] = 16'h1100; REQ_RELOAD[16 +: 16] = 16'h2211; REQ_RELOAD[48 +: 16] = 16'h4433;
    REQ = 4'b1011;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (TIMER_WR_LSB) lsb_bytes.push_back(int'(TIMERS_DATA));
      if (ACK != 0) begin
        at.push_back(cyc);
        for (int j = 0; j < N; j++) if (ACK[j]) begin order.push_back(j); REQ[j] = 0; end
      end
    end
    chk("rr_count", 32'(order.size()), 32'd3);
    chk("rr_first", 32'(order[0]), 32'd0);
    chk("rr_second", 32'(order[1]), 32'd1);
    chk("rr_third", 32'(order[2]), 32'd3);
    chk("rr_gap01", 32'(at[1] - at[0]), 32'd5);
    chk("rr_gap12", 32'(at[2] - at[1]), 32'd5);
    chk("rr_lsb0", 32'(lsb_bytes[0]), 32'h00);
    chk("rr_lsb1", 32'(lsb_bytes[1]), 32'h11);
    chk("rr_lsb3", 32'(lsb_bytes[2]), 32'h33);
    // fairness: core 0 keeps requesting, core 1 arrives once
    order.delete();
    REQ = 4'b0001;
    tick(1);
    REQ[1] = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge CLK);
      if (ACK != 0)
        for (int j = 0; j < N; j++) if (ACK[j]) begin order.push_back(j); if (j == 1) REQ[1] = 0; end
    end
    REQ = 0;
    chk("fair_count", 32'(order.size()), 32'd3);
    chk("fair_first", 32'(order[0]), 32'd0);
    chk("fair_second", 32'(order[1]), 32'd1);
    chk("fair_third", 32'(order[2]), 32'd0);
    tick(3);
    // latched reload is immune to mid-transaction changes
    REQ = 4'b0010; REQ_EN = 4'b0010; REQ_RELOAD[16 +: 16] = 16'h1234;
    tick(1);
    chk("stab_lsb_data", 32'(TIMERS_DATA), 32'h34);
    REQ_RELOAD[16 +: 16] = 16'hFFFF;
    tick(1);
    chk("stab_msb_data", 32'(TIMERS_DATA), 32'h12);
    tick(1);
    chk("stab_set_data", 32'(TIMERS_DATA), 32'h12);
    tick(1);
    chk("stab_ack", 32'(ACK), 32'b0010);
    REQ = 0; REQ_EN = 0;
    tick(2);
    // overflow servicing
    TIMER1_OV_Flag = 1;
    tick(1);
    chk("ov_read1", 32'(TIMER1_OV_Read), 32'd1);
    chk("ov_pend1", 32'(OV_PEND), 32'hF);
    TIMER1_OV_Flag = 0;
    tick(1);
    chk("ov_single", 32'(TIMER1_OV_Read), 32'd0);
    OV_CLR = 4'b0010;
    tick(1);
    chk("ov_clr1", 32'(OV_PEND), 32'hD);
    OV_CLR = 4'b0001; TIMER1_OV_Flag = 1;
    tick(1);
    chk("ov_set_wins", 32'(OV_PEND), 32'hF);
    OV_CLR = 0; TIMER1_OV_Flag = 0;
    tick(2);
    TIMER1_OV_Flag = 1;
    tick(1);
    chk("ov_pers_a", 32'(TIMER1_OV_Read), 32'd1);
    tick(1);
    chk("ov_pers_b", 32'(TIMER1_OV_Read), 32'd0);
    tick(1);
    chk("ov_pers_c", 32'(TIMER1_OV_Read), 32'd1);
    tick(3);
    TIMER1_OV_Flag = 0;
    tick(2);
    OV_CLR = 4'hF;
    tick(1);
    chk("ov_clr_all", 32'(OV_PEND), 32'h0);
    OV_CLR = 0;
    // reset during WR_MSB aborts, held request is re-served
    REQ = 4'b0100; REQ_EN = 4'b0100; REQ_RELOAD[32 +: 16] = 16'hBEEF;
    tick(1);
    chk("rst6_lsb", 32'(TIMER_WR_LSB), 32'd1);
    tick(1);
    chk("rst6_msb", 32'(TIMER_WR_MSB), 32'd1);
    CPU_Reset = 1;
    tick(1);
    chk("rst6_set", 32'(TIMER_SET_REGISTER), 32'd0);
    chk("rst6_ack", 32'(ACK), 32'd0);
    chk("rst6_en", 32'(TIMER1_EN), 32'd0);
    chk("rst6_busy", 32'(BUSY), 32'd0);
    CPU_Reset = 0;
    tick(1);
    chk("rst6_relsb", 32'(TIMER_WR_LSB), 32'd1);
    chk("rst6_redata", 32'(TIMERS_DATA), 32'hEF);
    tick(3);
    chk("rst6_reack", 32'(ACK), 32'b0100);
    chk("rst6_reen", 32'(TIMER1_EN), 32'd1);
    REQ = 0; REQ_EN = 0;
    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
